// File: rtl/plan_coef_pipe.sv
// Two-stage coefficient lookup for piecewise-linear activation approximation.
// Maps a float32 operand onto an octave-based segment and returns {slope, intercept} from a loadable table.
module plan_coef_pipe #(
  parameter int E_BASE = 125,
  parameter int NOCT   = 6,
  parameter int NMODES = 2,
  parameter int CW     = 32,
  localparam int IW    = NOCT + 1,
  localparam int MW    = (NMODES > 1) ? $clog2(NMODES) : 1,
  localparam int AW    = MW + 1 + IW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_x,
  input  logic [MW-1:0] in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_x,
  output logic [CW-1:0] out_cf1,
  output logic [CW-1:0] out_cf2,
  output logic [IW-1:0] out_idx,
  output logic          out_nan,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_cf1,
  input  logic [CW-1:0] cfg_cf2
);

  localparam int TDEPTH = 1 << AW;
  localparam logic [8:0] EBASE9 = 9'(E_BASE);
  localparam logic [8:0] ETOP9  = 9'(E_BASE + NOCT);
  localparam logic [IW-1:0] SAT_IDX = {1'b1, {NOCT{1'b0}}};

  logic [CW-1:0] tblCf1 [TDEPTH];
  logic [CW-1:0] tblCf2 [TDEPTH];

  logic          v1, v2;
  logic [31:0]   x1, x2;
  logic [MW-1:0] mode1;
  logic [IW-1:0] idx1, idx2;
  logic          nan1, nan2;
  logic [CW-1:0] cf1Reg, cf2Reg;

  logic [7:0]    expo;
  logic [4:0]    kSeg;
  logic [IW-1:0] idxNext;
  logic [MW-1:0] modeNext;
  logic          nanNext;
  logic          s1Load, s2Load;
  logic          cfgModeOk;
  logic [AW-1:0] rdAddr;

  assign expo     = in_x[30:23];
  assign kSeg     = 5'({1'b0, expo} - EBASE9);
  assign nanNext  = (expo == 8'hFF) && (in_x[22:0] != 23'd0);
  assign modeNext = (int'(in_mode) < NMODES) ? in_mode : '0;

  // Octave k is split into 2^k equal segments by the top k mantissa bits.
  always_comb begin
    idxNext = '0;
    if (expo == 8'd0 || {1'b0, expo} < EBASE9) begin
      idxNext = '0;
    end else if ({1'b0, expo} < ETOP9) begin
      idxNext = (IW'(1) << kSeg) | IW'(in_x[22:0] >> (5'd23 - kSeg));
    end else begin
      idxNext = SAT_IDX;
    end
  end

  assign s2Load   = !v2 || out_ready;
  assign s1Load   = !v1 || s2Load;
  assign in_ready = s1Load;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      v1    <= 1'b0;
      x1    <= '0;
      mode1 <= '0;
      idx1  <= '0;
      nan1  <= 1'b0;
    end else if (s1Load) begin
      v1 <= in_valid;
      if (in_valid) begin
        x1    <= in_x;
        mode1 <= modeNext;
        idx1  <= idxNext;
        nan1  <= nanNext;
      end
    end
  end

  assign rdAddr = {mode1, x1[31], idx1};

  // Table is read with pre-edge contents, so a colliding write is seen by the next read.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      v2     <= 1'b0;
      x2     <= '0;
      cf1Reg <= '0;
      cf2Reg <= '0;
      idx2   <= '0;
      nan2   <= 1'b0;
    end else if (s2Load) begin
      v2 <= v1;
      if (v1) begin
        x2     <= x1;
        cf1Reg <= tblCf1[rdAddr];
        cf2Reg <= tblCf2[rdAddr];
        idx2   <= idx1;
        nan2   <= nan1;
      end
    end
  end

  assign cfgModeOk = int'(cfg_addr[AW-1 -: MW]) < NMODES;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < TDEPTH; i++) begin
        tblCf1[i] <= '0;
        tblCf2[i] <= '0;
      end
    end else if (cfg_we && cfgModeOk) begin
      tblCf1[cfg_addr] <= cfg_cf1;
      tblCf2[cfg_addr] <= cfg_cf2;
    end
  end

  assign out_valid = v2;
  assign out_x     = x2;
  assign out_cf1   = cf1Reg;
  assign out_cf2   = cf2Reg;
  assign out_idx   = idx2;
  assign out_nan   = nan2;

endmodule

// File: tb/tb_plan_coef_pipe.sv
// Scoreboard bench for plan_coef_pipe: a reference model predicts each accepted beat,
// and a monitor compares whatever the DUT hands out, including hold-stability under backpressure.
module tb_plan_coef_pipe;

  localparam int E_BASE = 125;
  localparam int NOCT   = 6;
  localparam int NMODES = 2;
  localparam int CW     = 32;
  localparam int IW     = NOCT + 1;
  localparam int MW     = 1;
  localparam int AW     = MW + 1 + IW;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_x = '0;
  logic [MW-1:0] in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_x;
  logic [CW-1:0] out_cf1, out_cf2;
  logic [IW-1:0] out_idx;
  logic          out_nan;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_cf1 = '0, cfg_cf2 = '0;

  plan_coef_pipe #(.E_BASE(E_BASE), .NOCT(NOCT), .NMODES(NMODES), .CW(CW)) dut (
    .clk(clk), .res(res),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_cf1(out_cf1), .out_cf2(out_cf2), .out_idx(out_idx), .out_nan(out_nan),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_cf1(cfg_cf1), .cfg_cf2(cfg_cf2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] cf1;
    logic [31:0] cf2;
    int          idx;
    bit          nan;
  } beat_t;

  beat_t       sbQ[$];
  logic [31:0] refCf1 [512];
  logic [31:0] refCf2 [512];
  int          checks = 0;
  int          errors = 0;
  int          acceptedCount = 0;
  int          stallCount = 0;
  bit          randRun = 0;

  // Segment of |x|: below 2^(E_BASE-127) -> 0, octave k holds 2^k equal slices, beyond -> saturation.
  function automatic int refIndex(logic [31:0] x);
    int     e;
    int     k;
    longint frac;
    e = int'(x[30:23]);
    if (e < E_BASE) return 0;
    if (e >= E_BASE + NOCT) return 1 << NOCT;
    k = e - E_BASE;
    frac = longint'(x[22:0]);
    return (1 << k) + int'((frac << k) >> 23);
  endfunction

  function automatic int refKey(int mode, int sign, int idx);
    return mode * 256 + sign * 128 + idx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 512; i++) begin
      refCf1[i] = '0;
      refCf2[i] = '0;
    end
  endtask

  // Caller sits just after a rising edge; returns one edge later, again just after it.
  task automatic cfgWrite(input int mode, input int sign, input int idx,
                          input logic [31:0] c1, input logic [31:0] c2);
    logic [AW-1:0] a;
    a = {mode[0], sign[0], idx[IW-1:0]};
    cfg_addr = a;
    cfg_cf1  = c1;
    cfg_cf2  = c2;
    cfg_we   = 1'b1;
    @(posedge clk);
    refCf1[refKey(mode, sign, idx)] = c1;
    refCf2[refKey(mode, sign, idx)] = c2;
    #1 cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] x, input int mode);
    bit    acc;
    bit    rdy;
    beat_t b;
    int    key;
    acc = 0;
    in_x = x;
    in_mode = 1'(mode);
    in_valid = 1'b1;
    for (int w = 0; w < 50 && !acc; w++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc = 1;
      else stallCount++;
    end
    if (acc) begin
      key   = refKey((mode < NMODES) ? mode : 0, int'(x[31]), refIndex(x));
      b.x   = x;
      b.idx = refIndex(x);
      b.nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      b.cf1 = refCf1[key];
      b.cf2 = refCf2[key];
      sbQ.push_back(b);
      acceptedCount++;
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready=0 for 50 cycles, expected 1");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    @(posedge clk);
    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending beats, expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  // Monitor: compare each handshaken output, and check outputs stay frozen while stalled.
  initial begin
    bit          held;
    logic [31:0] hX, hC1, hC2, hIdx;
    logic        hNan;
    beat_t       e;
    held = 0;
    forever begin
      @(negedge clk);
      if (!res || !out_valid) begin
        held = 0;
      end else begin
        if (held) begin
          checkOutput("hold x",   out_x,   hX);
          checkOutput("hold cf1", out_cf1, hC1);
          checkOutput("hold cf2", out_cf2, hC2);
          checkOutput("hold idx", 32'(out_idx), hIdx);
          checkOutput("hold nan", 32'(out_nan), 32'(hNan));
        end
        if (out_ready) begin
          held = 0;
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected output: got x=%h, expected no beat", out_x);
          end else begin
            e = sbQ.pop_front();
            checkOutput("out_x",   out_x,   e.x);
            checkOutput("out_cf1", out_cf1, e.cf1);
            checkOutput("out_cf2", out_cf2, e.cf2);
            checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
            checkOutput("out_nan", 32'(out_nan), 32'(e.nan));
          end
        end else begin
          held = 1;
          hX = out_x; hC1 = out_cf1; hC2 = out_cf2; hIdx = 32'(out_idx); hNan = out_nan;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] decodeX [6];
    logic [31:0] rx;
    int          base;
    int          seen;

    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_x",     out_x,   32'd0);
    checkOutput("reset out_cf1",   out_cf1, 32'd0);
    checkOutput("reset out_idx",   32'(out_idx), 32'd0);
    res = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // First beat: zero operand hits segment 0, two-cycle latency.
    cfgWrite(0, 0, 0, 32'h3E7ECE00, 32'h3F000442);
    applyStimulus(32'h00000000, 0);
    @(negedge clk);
    checkOutput("latency cycle 1 valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency cycle 2 valid", 32'(out_valid), 32'd1);
    checkOutput("first cf1", out_cf1, 32'h3E7ECE00);
    checkOutput("first cf2", out_cf2, 32'h3F000442);
    checkOutput("first idx", 32'(out_idx), 32'd0);
    waitDrain();

    for (int m = 0; m < NMODES; m++)
      for (int s = 0; s < 2; s++)
        for (int i = 0; i <= (1 << NOCT); i++)
          cfgWrite(m, s, i, $urandom, $urandom);

    // Index decode, back to back with no stall.
    decodeX[0] = 32'h3E99999A; decodeX[1] = 32'h3F800000; decodeX[2] = 32'hBFC00000;
    decodeX[3] = 32'h40200000; decodeX[4] = 32'h42C80000; decodeX[5] = 32'h7FC00000;
    checkOutput("model idx 2.5", 32'(refIndex(decodeX[3])), 32'd10);
    stallCount = 0;
    for (int i = 0; i < 6; i++) applyStimulus(decodeX[i], 0);
    checkOutput("decode stalls", 32'(stallCount), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("decode throughput pending", 32'(sbQ.size()), 32'd0);
    waitDrain();

    // Backpressure: only two beats fit while the sink is stalled.
    out_ready = 1'b0;
    base = acceptedCount;
    fork
      for (int i = 0; i < 4; i++) applyStimulus(32'h3F800000 + 32'(i << 20), i & 1);
      begin
        repeat (6) @(negedge clk);
        checkOutput("bp accepted", 32'(acceptedCount - base), 32'd2);
        checkOutput("bp in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();

    // Mode banking.
    cfgWrite(1, 0, 4, 32'hCAFE0001, 32'hBEEF0002);
    applyStimulus(32'h3F800000, 0);
    applyStimulus(32'h3F800000, 1);
    waitDrain();

    // Write colliding with the S2 read returns the old entry; the repeat sees the new one.
    applyStimulus(32'h3F800000, 0);
    cfgWrite(0, 0, 4, 32'h12345678, 32'h9ABCDEF0);
    applyStimulus(32'h3F800000, 0);
    waitDrain();

    // Randomized traffic with random sink stalls.
    randRun = 1;
    fork
      while (randRun) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       rx = {1'($urandom), 8'd0, 23'($urandom)};
        1:       rx = {1'($urandom), 8'hFF, (($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom))};
        2:       rx = $urandom;
        default: rx = {1'($urandom), 8'($urandom_range(120, 133)), 23'($urandom)};
      endcase
      applyStimulus(rx, $urandom_range(0, NMODES - 1));
    end
    randRun = 0;
    wait fork;
    out_ready = 1'b1;
    waitDrain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    applyStimulus(32'h3F800000, 0);
    applyStimulus(32'h40200000, 1);
    res = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-reset out_x",     out_x,   32'd0);
    checkOutput("mid-reset out_cf1",   out_cf1, 32'd0);
    checkOutput("mid-reset out_cf2",   out_cf2, 32'd0);
    checkOutput("mid-reset out_idx",   32'(out_idx), 32'd0);
    checkOutput("mid-reset out_nan",   32'(out_nan), 32'd0);
    sbQ.delete();
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("post-reset idle valids", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(32'h3F800000, 0);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plan_coef_pipe.md
Name: plan_coef_pipe

Overview:
- Parametrised, pipelined successor to the fixed-table PLAN coefficient controller for piecewise-linear activation approximation.
- Takes an IEEE-754 single-precision x and a mode select (e.g. sigmoid/tanh), and returns slope (cf1) and intercept (cf2) from a runtime-loadable coefficient table.
- Uses a non-uniform, octave-based segmentation and a valid/ready handshake.
- Sits in front of the FP multiply-add that forms cf1*x+cf2.

Parameters:
E_BASE, 125, lowest biased exponent that has its own segment; smaller exponents map to idx 0.
NOCT, 6, number of octaves segmented (E_BASE..E_BASE+NOCT-1); IW = NOCT+1 index bits.
NMODES, 2, number of coefficient banks (functions); MW = max(1, clog2(NMODES)).
CW, 32, coefficient width (float32 bit patterns, opaque to this block).

Ports:
clk  in  1  clock, all state on rising edge
res  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input
in_x  in  32  float32 operand
in_mode  in  MW  coefficient bank select, captured with in_x
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_x  out  32  in_x delayed, aligned with coefficients
out_cf1  out  CW  slope
out_cf2  out  CW  intercept
out_idx  out  IW  segment index used (debug/verification)
out_nan  out  1  in_x was NaN (exp=255, mantissa!=0)
cfg_we  in  1  table write strobe
cfg_addr  in  MW+1+IW  {mode, sign, idx}
cfg_cf1  in  CW  slope to write
cfg_cf2  in  CW  intercept to write

Behaviour:
- Reset (res=0, async):
  - All valids, out_x, out_cf1, out_cf2, out_idx, out_nan clear to 0.
  - Every table entry clears to {0,0}.
  - in_ready is 1 from the first cycle after release.
- Index computation (stage 1), with e = in_x[30:23], k = e-E_BASE:
  - e < E_BASE -> idx = 0.
  - E_BASE <= e < E_BASE+NOCT -> idx = 2^k + in_x[22 -: k] (top k mantissa bits; k=0 gives idx=1).
  - e >= E_BASE+NOCT (incl. Inf/NaN) -> idx = 2^NOCT (saturation segment).
  - Denormals and ±0 -> idx 0.
  - Sign bit selects the sign half of the table; no symmetry arithmetic is done in hardware, so software loads both halves.
- Pipeline, two stages, latency 2 cycles with no stall:
  - S1 registers x, mode, idx, nan.
  - S2 registers table[{mode,sign,idx}] plus the S1 fields.
  - Each stage loads when its own valid=0 or the downstream stage accepts.
  - in_ready = !v1 | (!v2 | out_ready).
  - S2 holds all outputs stable while out_valid=1 and out_ready=0.
  - Full throughput of 1 beat/cycle when out_ready=1.
  - Maximum 2 beats in flight; order is preserved and no beat is dropped or duplicated.
- Table:
  - NMODES*2*2^IW entries of {cf1,cf2}; entries with idx > 2^NOCT are unused but writable.
  - cfg_we writes take effect at the clock edge.
  - A same-cycle write and S2 read of the same address returns the OLD value; the next read returns the new one.
  - Writes are accepted at any time, independent of the handshake, and never stall the pipe.
- in_mode >= NMODES (non-power-of-2 NMODES): treated as mode 0. Any cfg write to such a mode is ignored.
- Reset mid-operation flushes in-flight beats; no output valid follows until new input.

Test Plan:
- Load (m0,s0,idx0)={0x3E7ECE00,0x3F000442}; send x=0x00000000, mode 0 -> 2 cycles later out_valid=1, out_idx=0, cf1=0x3E7ECE00, cf2=0x3F000442, out_x=0.
- Index decode, mode 0 with out_ready=1, back-to-back inputs:
  - 0x3E99999A (0.3) -> idx 1.
  - 0x3F800000 (1.0) -> idx 4.
  - 0xBFC00000 (-1.5) -> idx 6 with sign-1 half.
  - 0x40200000 (2.5) -> idx 10.
  - 0x42C80000 (100.0) -> idx 64.
  - 0x7FC00000 -> idx 64 and out_nan=1.
  - One result per cycle, in order.
- Backpressure: hold out_ready=0, offer 4 beats -> in_ready drops after 2 are accepted. Outputs hold steady. Releasing out_ready delivers all 4 in order with no loss.
- Mode banking: write a different entry at (m1,s0,idx4); send 1.0 with mode 0 then mode 1 -> each returns its own bank's coefficients.
- Write/read collision: write (m0,s0,idx4) in the same cycle S2 reads it -> old value returned; a repeat of x=1.0 returns the new value.
- Assert res low with 2 beats in flight -> out_valid=0 and all outputs and the table read 0 immediately. After release, x=1.0 returns cf1=cf2=0.
